dual_port_ram_pipe: RTL

- Parametrised simple dual-port RAM: one write port and one read port on a single clock.
- Successor to the FIFO storage model. Adds byte-enable writes, a selectable read latency (1 or 2), a read-valid strobe and a selectable read-during-write policy with per-byte forwarding.
- Serves as the storage element under the sync/async FIFOs and line buffers in 5_memory.

---
 rtl/mem_pkg.sv | 15 +
 rtl/ram_rd_forward.sv | 38 +++
 rtl/dual_port_ram_pipe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory blocks: read-during-write policy codes
// and the lane-merge helper used by the byte-enable forwarding logic.
package mem_pkg;

  // Read-during-write policy codes
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Lane select: a set enable picks the new value, otherwise the old value is kept.
  // Callers apply it bit by bit, passing the enable of the lane that owns the bit.
  function automatic logic merge(input logic old_bit, input logic new_bit, input logic be);
    return be ? new_bit : old_bit;
  endfunction

endpackage

// File: rtl/ram_rd_forward.sv
// Combinational per-lane forwarding mux for the read port.
// Each byte lane of the result comes from the youngest matching source:
// the write on the port this cycle, then the staged write, then the array.
module ram_rd_forward
  import mem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = 8,
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = WIDTH / BYTE_W
) (
  input  logic [WIDTH-1:0]     arr_word,
  input  logic                 ws_valid,
  input  logic [DEPTH_LOG-1:0] ws_addr,
  input  logic [WIDTH-1:0]     ws_data,
  input  logic [NUM_BYTES-1:0] ws_be,
  input  logic                 wr_en,
  input  logic [DEPTH_LOG-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NUM_BYTES-1:0] wr_be,
  input  logic [DEPTH_LOG-1:0] rd_addr,
  output logic [WIDTH-1:0]     fwd_word
);

  logic             ws_hit;
  logic             wr_hit;
  logic [WIDTH-1:0] stg_word;

  assign ws_hit = ws_valid && (ws_addr == rd_addr);
  assign wr_hit = wr_en && (wr_addr == rd_addr);

  // Staged write overrides the array, then the port write overrides both, lane by lane.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    assign stg_word[b] = merge(arr_word[b], ws_data[b], ws_hit & ws_be[b / BYTE_W]);
    assign fwd_word[b] = merge(stg_word[b], wr_data[b], wr_hit & wr_be[b / BYTE_W]);
  end

endmodule

// File: rtl/dual_port_ram_pipe.sv
// Simple dual-port RAM, one write and one read port on a single clock.
// Writes go through a one-deep stage and commit on the following edge with
// byte enables. Reads return data after 1 or 2 edges with a one-cycle
// rd_valid strobe; optional per-lane forwarding covers writes not yet in
// the array.
//
// Handshake: there is no backpressure. rd_en is a request accepted on every
// rising edge where it is high; rd_valid is high for exactly one cycle per
// accepted request, READ_LATENCY edges later, in request order. rd_data
// keeps its value between strobes.
module dual_port_ram_pipe #(
  parameter int WIDTH        = 32,
  parameter int DEPTH_LOG    = 8,
  parameter int BYTE_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_NEW      = mem_pkg::RDW_NEW,
  localparam int NUM_BYTES   = WIDTH / BYTE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DEPTH_LOG-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NUM_BYTES-1:0] wr_be,
  input  logic                 rd_en,
  input  logic [DEPTH_LOG-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  // Reject configurations the datapath cannot represent.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dual_port_ram_pipe: READ_LATENCY must be 1 or 2");
  end
  if (WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("dual_port_ram_pipe: WIDTH must be a multiple of BYTE_W");
  end

  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 ws_valid;
  logic [DEPTH_LOG-1:0] ws_addr;
  logic [WIDTH-1:0]     ws_data;
  logic [NUM_BYTES-1:0] ws_be;

  logic [WIDTH-1:0]     arr_word;
  logic [WIDTH-1:0]     rd_word;
  logic                 r1_valid;
  logic [WIDTH-1:0]     r1_data;

  // Write stage: an all-zero byte enable is a no-op and leaves the stage empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_valid <= 1'b0;
      ws_addr  <= '0;
      ws_data  <= '0;
      ws_be    <= '0;
    end else begin
      ws_valid <= wr_en && (|wr_be);
      ws_addr  <= wr_addr;
      ws_data  <= wr_data;
      ws_be    <= wr_en ? wr_be : '0;
    end
  end

  // Array commit: enabled lanes of the staged write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ws_valid) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (ws_be[i]) mem[ws_addr][i*BYTE_W +: BYTE_W] <= ws_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // The array is read before this edge's commit lands.
  assign arr_word = mem[rd_addr];

  if (RDW_NEW == mem_pkg::RDW_NEW) begin : g_fwd
    ram_rd_forward #(
      .WIDTH     (WIDTH),
      .DEPTH_LOG (DEPTH_LOG),
      .BYTE_W    (BYTE_W),
      .NUM_BYTES (NUM_BYTES)
    ) u_fwd (
      .arr_word (arr_word),
      .ws_valid (ws_valid),
      .ws_addr  (ws_addr),
      .ws_data  (ws_data),
      .ws_be    (ws_be),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .rd_addr  (rd_addr),
      .fwd_word (rd_word)
    );
  end else begin : g_no_fwd
    assign rd_word = arr_word;
  end

  // First read register: captures the (possibly forwarded) word on each request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_data  <= '0;
    end else begin
      r1_valid <= rd_en;
      if (rd_en) r1_data <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             r2_valid;
    logic [WIDTH-1:0] r2_data;

    // Second read register: re-times the first stage by one edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r2_valid <= 1'b0;
        r2_data  <= '0;
      end else begin
        r2_valid <= r1_valid;
        if (r1_valid) r2_data <= r1_data;
      end
    end

    assign rd_valid = r2_valid;
    assign rd_data  = r2_data;
  end else begin : g_lat1
    assign rd_valid = r1_valid;
    assign rd_data  = r1_data;
  end

endmodule
